// File: rtl/pipe_ctrl_if.sv
// Pipeline-to-controller bundle: stage register/control info in, forward/stall/flush/md status out.
// The master side is the hazard controller; the slave side is the datapath.
interface pipe_ctrl_if;
    logic [4:0] d_srca;
    logic [4:0] d_srcb;
    logic       d_uses_a;
    logic       d_uses_b;
    logic       d_is_branch;
    logic [4:0] e_dst;
    logic       e_regwrite;
    logic       e_memtoreg;
    logic [4:0] e_srca;
    logic [4:0] e_srcb;
    logic [4:0] m_dst;
    logic       m_regwrite;
    logic       m_memtoreg;
    logic [4:0] w_dst;
    logic       w_regwrite;
    logic       md_start;
    logic       md_is_div;
    logic       i_stall;
    logic       d_stall;
    logic       exc_valid;
    logic [1:0] forwardAD;
    logic [1:0] forwardBD;
    logic [1:0] forwardAE;
    logic [1:0] forwardBE;
    logic       stallF;
    logic       stallD;
    logic       stallE;
    logic       stallM;
    logic       flushD;
    logic       flushE;
    logic       flushM;
    logic       flushW;
    logic       md_busy;
    logic       md_finish;

    modport master (
        input  d_srca, d_srcb, d_uses_a, d_uses_b, d_is_branch,
        input  e_dst, e_regwrite, e_memtoreg, e_srca, e_srcb,
        input  m_dst, m_regwrite, m_memtoreg, w_dst, w_regwrite,
        input  md_start, md_is_div, i_stall, d_stall, exc_valid,
        output forwardAD, forwardBD, forwardAE, forwardBE,
        output stallF, stallD, stallE, stallM,
        output flushD, flushE, flushM, flushW,
        output md_busy, md_finish
    );

    modport slave (
        output d_srca, d_srcb, d_uses_a, d_uses_b, d_is_branch,
        output e_dst, e_regwrite, e_memtoreg, e_srca, e_srcb,
        output m_dst, m_regwrite, m_memtoreg, w_dst, w_regwrite,
        output md_start, md_is_div, i_stall, d_stall, exc_valid,
        input  forwardAD, forwardBD, forwardAE, forwardBE,
        input  stallF, stallD, stallE, stallM,
        input  flushD, flushE, flushM, flushW,
        input  md_busy, md_finish
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Hazard, forwarding and stall/flush sequencer for the 5-stage MIPS pipeline,
// including the IDLE/RUN sequencer that holds a mult/div in E for its latency.
module pipe_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic          clk,
    input  logic          resetn,
    pipe_ctrl_if.master   bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    // Counter is loaded with LAT-1 so finish lands LAT cycles after entering RUN.
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic lu_s;
    logic br_s;
    logic mem_s;
    logic md_stall_s;
    logic md_finish_s;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] m_dst,
        input logic       m_rw,
        input logic [4:0] w_dst,
        input logic       w_rw
    );
        logic [1:0] sel;
        if (src != 5'd0 && m_rw && m_dst == src) begin
            sel = 2'b01;
        end else if (src != 5'd0 && w_rw && w_dst == src) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    function automatic logic src_hit(
        input logic [4:0] dst,
        input logic [4:0] srca,
        input logic       uses_a,
        input logic [4:0] srcb,
        input logic       uses_b
    );
        return (dst != 5'd0) && ((uses_a && dst == srca) || (uses_b && dst == srcb));
    endfunction

    // Hazard terms.
    always_comb begin
        mem_s = bus.i_stall | bus.d_stall;
        lu_s  = bus.e_regwrite & bus.e_memtoreg &
                src_hit(bus.e_dst, bus.d_srca, bus.d_uses_a, bus.d_srcb, bus.d_uses_b);
        br_s  = bus.d_is_branch &
                ((bus.e_regwrite & src_hit(bus.e_dst, bus.d_srca, bus.d_uses_a, bus.d_srcb, bus.d_uses_b)) |
                 (bus.m_memtoreg & src_hit(bus.m_dst, bus.d_srca, bus.d_uses_a, bus.d_srcb, bus.d_uses_b)));
    end

    // Mult/div sequencer next state; the counter freezes while a cache miss is pending.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        md_stall_s  = 1'b0;
        md_finish_s = 1'b0;
        if (bus.exc_valid) begin
            state_d = IDLE;
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.md_start && !mem_s) begin
                        cnt_d      = bus.md_is_div ? DIV_CNT : MUL_CNT;
                        state_d    = RUN;
                        md_stall_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    if (cnt_q != {CNT_W{1'b0}}) begin
                        md_stall_s = 1'b1;
                        if (!mem_s) begin
                            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                        end else begin
                            cnt_d = cnt_q;
                        end
                    end else if (!mem_s) begin
                        md_finish_s = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stall/flush priority chain and forwarding selects; reset holds every stage flushed.
    always_comb begin
        bus.forwardAD = 2'b00;
        bus.forwardBD = 2'b00;
        bus.forwardAE = 2'b00;
        bus.forwardBE = 2'b00;
        bus.stallF    = 1'b0;
        bus.stallD    = 1'b0;
        bus.stallE    = 1'b0;
        bus.stallM    = 1'b0;
        bus.flushD    = 1'b0;
        bus.flushE    = 1'b0;
        bus.flushM    = 1'b0;
        bus.flushW    = 1'b0;
        bus.md_busy   = resetn & (state_q == RUN);
        bus.md_finish = resetn & md_finish_s;
        if (!resetn) begin
            bus.flushD = 1'b1;
            bus.flushE = 1'b1;
            bus.flushM = 1'b1;
            bus.flushW = 1'b1;
        end else begin
            bus.forwardAD = fwd_sel(bus.d_srca, bus.m_dst, bus.m_regwrite, bus.w_dst, bus.w_regwrite);
            bus.forwardBD = fwd_sel(bus.d_srcb, bus.m_dst, bus.m_regwrite, bus.w_dst, bus.w_regwrite);
            bus.forwardAE = fwd_sel(bus.e_srca, bus.m_dst, bus.m_regwrite, bus.w_dst, bus.w_regwrite);
            bus.forwardBE = fwd_sel(bus.e_srcb, bus.m_dst, bus.m_regwrite, bus.w_dst, bus.w_regwrite);
            if (bus.exc_valid) begin
                bus.flushD = 1'b1;
                bus.flushE = 1'b1;
                bus.flushM = 1'b1;
            end else if (mem_s) begin
                bus.stallF = 1'b1;
                bus.stallD = 1'b1;
                bus.stallE = 1'b1;
                bus.stallM = 1'b1;
                bus.flushW = 1'b1;
            end else if (md_stall_s) begin
                bus.stallF = 1'b1;
                bus.stallD = 1'b1;
                bus.stallE = 1'b1;
                bus.flushM = 1'b1;
            end else if (lu_s || br_s) begin
                bus.stallF = 1'b1;
                bus.stallD = 1'b1;
                bus.flushE = 1'b1;
            end else begin
                bus.stallF = 1'b0;
            end
        end
    end

endmodule
